// File: rtl/runway_pkg.sv
// Shared types for the runway light decoder: wind codes, step classes, legal lamp patterns.
// Latency: none (types only). Backpressure: none.
package runway_pkg;

   typedef enum logic [1:0] {
      WIND_CALM  = 2'b00,
      WIND_LEFT  = 2'b01,
      WIND_RIGHT = 2'b10
   } wind_e;

   typedef enum logic [2:0] {
      STEP_CALM,
      STEP_LEFT,
      STEP_RIGHT,
      STEP_HOLD,
      STEP_ILLEGAL
   } step_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRACK,
      ST_LOCKED
   } state_e;

   localparam logic [2:0] PAT_001 = 3'b001;
   localparam logic [2:0] PAT_010 = 3'b010;
   localparam logic [2:0] PAT_100 = 3'b100;
   localparam logic [2:0] PAT_101 = 3'b101;

   function automatic wind_e step_to_wind(input step_e s);
      case (s)
         STEP_LEFT:  return WIND_LEFT;
         STEP_RIGHT: return WIND_RIGHT;
         default:    return WIND_CALM;
      endcase
   endfunction

endpackage

// File: rtl/runway_step_classify.sv
// Classifies one lamp-pattern step (previous -> current) and flags illegal current patterns.
// Latency: combinational. Backpressure: none.
module runway_step_classify
   import runway_pkg::*;
(
   input  logic [2:0] prev_i,
   input  logic [2:0] cur_i,
   output step_e      step_o,
   output logic       illegal_pat_o
);

   always_comb begin
      illegal_pat_o = !(cur_i inside {PAT_001, PAT_010, PAT_100, PAT_101});
      step_o        = STEP_ILLEGAL;
      if (cur_i == prev_i) begin
         step_o = STEP_HOLD;
      end else begin
         case ({prev_i, cur_i})
            {PAT_101, PAT_010}, {PAT_010, PAT_101}:                     step_o = STEP_CALM;
            {PAT_001, PAT_010}, {PAT_010, PAT_100}, {PAT_100, PAT_001}: step_o = STEP_LEFT;
            {PAT_100, PAT_010}, {PAT_010, PAT_001}, {PAT_001, PAT_100}: step_o = STEP_RIGHT;
            default:                                                    step_o = STEP_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/runway_pattern_decoder.sv
// Decodes wind direction from runway lamp sequences; RUNWAY_DEC_STATS_EN adds an 8-bit saturating err_count.
// Latency: 1 cycle from sampling edge to registered outputs. Backpressure: none, samples gated by sample_valid.
module runway_pattern_decoder
   import runway_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] lights,
   input  logic       sample_valid,
   output logic [1:0] wind,
   output logic       locked,
   output logic       err,
   output logic       dir_change
`ifdef RUNWAY_DEC_STATS_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

   state_e     state_q;
   logic [2:0] prev_q;
   step_e      cand_q, cand_d;
   logic [3:0] run_q, run_d;
   wind_e      wind_q;
   logic       locked_q, err_q, dir_change_q;
   step_e      step;
   logic       illegal_pat;
   logic       lock_hit;

   runway_step_classify u_classify (
      .prev_i        (prev_q),
      .cur_i         (lights),
      .step_o        (step),
      .illegal_pat_o (illegal_pat)
   );

   // A new class restarts the run at 1; a repeat of the candidate counts up and saturates.
   always_comb begin
      cand_d = cand_q;
      run_d  = run_q;
      if (step == cand_q) begin
         run_d = (run_q >= LOCK_N) ? LOCK_N : run_q + 4'd1;
      end else begin
         cand_d = step;
         run_d  = 4'd1;
      end
      lock_hit = (run_d == LOCK_N);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         prev_q       <= 3'b000;
         cand_q       <= STEP_CALM;
         run_q        <= 4'd0;
         wind_q       <= WIND_CALM;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
         dir_change_q <= 1'b0;
      end else begin
         err_q        <= 1'b0;
         dir_change_q <= 1'b0;
         if (sample_valid) begin
            if (illegal_pat) begin
               err_q    <= 1'b1;
               locked_q <= 1'b0;
               wind_q   <= WIND_CALM;
               run_q    <= 4'd0;
               state_q  <= ST_IDLE;
            end else if (state_q == ST_IDLE) begin
               prev_q  <= lights;
               run_q   <= 4'd0;
               state_q <= ST_TRACK;
            end else begin
               case (step)
                  STEP_HOLD: ;
                  STEP_ILLEGAL: begin
                     err_q    <= 1'b1;
                     locked_q <= 1'b0;
                     wind_q   <= WIND_CALM;
                     prev_q   <= lights;
                     run_q    <= 4'd0;
                     state_q  <= ST_TRACK;
                  end
                  default: begin
                     prev_q <= lights;
                     cand_q <= cand_d;
                     run_q  <= run_d;
                     if (lock_hit) begin
                        if (state_q == ST_TRACK) begin
                           wind_q   <= step_to_wind(cand_d);
                           locked_q <= 1'b1;
                           state_q  <= ST_LOCKED;
                        end else if (step_to_wind(cand_d) != wind_q) begin
                           wind_q       <= step_to_wind(cand_d);
                           dir_change_q <= 1'b1;
                        end
                     end
                  end
               endcase
            end
         end
      end
   end

   assign wind       = wind_q;
   assign locked     = locked_q;
   assign err        = err_q;
   assign dir_change = dir_change_q;

`ifdef RUNWAY_DEC_STATS_EN
   logic [7:0] err_count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count_q <= 8'd0;
      end else if (err_q && err_count_q != 8'hFF) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end

   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_runway_pattern_decoder.sv
// Scoreboard bench for runway_pattern_decoder: driver queues expected outputs, monitor compares them.
module tb_runway_pattern_decoder;

   typedef struct packed {
      logic [1:0] wind;
      logic       locked;
      logic       err;
      logic       dc;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] lights = 3'b000;
   logic       sample_valid = 1'b0;
   logic [1:0] wind, wind1;
   logic       locked, err, dir_change;
   logic       locked1, err1, dir_change1;
`ifdef RUNWAY_DEC_STATS_EN
   logic [7:0] err_count, err_count1;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   obs_t  exp_q[$];
   string name_q[$];

   always #5 clk = ~clk;

   runway_pattern_decoder #(.LOCK_COUNT(3)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .lights       (lights),
      .sample_valid (sample_valid),
      .wind         (wind),
      .locked       (locked),
      .err          (err),
      .dir_change   (dir_change)
`ifdef RUNWAY_DEC_STATS_EN
      ,
      .err_count    (err_count)
`endif
   );

   runway_pattern_decoder #(.LOCK_COUNT(1)) u_dut1 (
      .clk          (clk),
      .reset_n      (reset_n),
      .lights       (lights),
      .sample_valid (sample_valid),
      .wind         (wind1),
      .locked       (locked1),
      .err          (err1),
      .dir_change   (dir_change1)
`ifdef RUNWAY_DEC_STATS_EN
      ,
      .err_count    (err_count1)
`endif
   );

   task automatic chk(input string nm, input obs_t act, input obs_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got wind=%b locked=%b err=%b dir_change=%b, expected wind=%b locked=%b err=%b dir_change=%b",
                    nm, act.wind, act.locked, act.err, act.dc, exp.wind, exp.locked, exp.err, exp.dc);
   endtask

   // Monitor: outputs after each driven edge are compared against the queued expectation.
   initial begin
      obs_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, {wind, locked, err, dir_change}, e);
         end
      end
   end

   task automatic step(input logic v, input logic [2:0] p, input logic [1:0] w,
                       input logic l, input logic e, input logic d, input string nm);
      @(negedge clk);
      sample_valid = v;
      lights       = p;
      exp_q.push_back({w, l, e, d});
      name_q.push_back(nm);
   endtask

   task automatic do_reset();
      @(negedge clk);
      sample_valid = 1'b0;
      reset_n      = 1'b0;
      #2;
      chk("reset_outputs", {wind, locked, err, dir_change}, 5'b0);
`ifdef RUNWAY_DEC_STATS_EN
      n_checks++;
      if (err_count === 8'd0) n_pass++;
      else $display("FAIL reset_err_count: got %0d, expected 0", err_count);
`endif
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      do_reset();

      // Calm: alternating 101/010 locks with wind 00.
      step(1, 3'b101, 2'b00, 0, 0, 0, "calm_first");
      step(1, 3'b010, 2'b00, 0, 0, 0, "calm_r1");
      @(posedge clk); #2;
      chk("lc1_calm_lock", {wind1, locked1, err1, dir_change1}, {2'b00, 1'b1, 1'b0, 1'b0});
      step(1, 3'b101, 2'b00, 0, 0, 0, "calm_r2");
      step(1, 3'b010, 2'b00, 1, 0, 0, "calm_lock");

      // Leftward lock, then rightward takeover and back.
      do_reset();
      step(1, 3'b001, 2'b00, 0, 0, 0, "left_first");
      step(1, 3'b010, 2'b00, 0, 0, 0, "left_r1");
      step(1, 3'b100, 2'b00, 0, 0, 0, "left_r2");
      step(1, 3'b001, 2'b01, 1, 0, 0, "left_lock");
      step(1, 3'b100, 2'b01, 1, 0, 0, "right_r1");
      @(posedge clk); #2;
      chk("lc1_dir_change", {wind1, locked1, err1, dir_change1}, {2'b10, 1'b1, 1'b0, 1'b1});
      step(1, 3'b010, 2'b01, 1, 0, 0, "right_r2");
      step(1, 3'b001, 2'b10, 1, 0, 1, "right_take");
      step(1, 3'b100, 2'b10, 1, 0, 0, "right_sat");
      step(1, 3'b001, 2'b10, 1, 0, 0, "back_left_r1");
      step(1, 3'b010, 2'b10, 1, 0, 0, "back_left_r2");
      step(1, 3'b100, 2'b01, 1, 0, 1, "back_left_take");

      // Illegal pattern while locked, gated sample, relock.
      step(0, 3'b111, 2'b01, 1, 0, 0, "gated_illegal");
      step(1, 3'b111, 2'b00, 0, 1, 0, "illegal_pat");
      step(1, 3'b001, 2'b00, 0, 0, 0, "relock_first");
      step(1, 3'b010, 2'b00, 0, 0, 0, "relock_r1");
      step(1, 3'b100, 2'b00, 0, 0, 0, "relock_r2");
      step(1, 3'b001, 2'b01, 1, 0, 0, "relock");

      // Illegal transition between legal patterns lands in TRACK.
      do_reset();
      step(1, 3'b101, 2'b00, 0, 0, 0, "itr_first");
      step(1, 3'b001, 2'b00, 0, 1, 0, "itr_err");
      step(1, 3'b010, 2'b00, 0, 0, 0, "itr_r1");
      step(1, 3'b100, 2'b00, 0, 0, 0, "itr_r2");
      step(1, 3'b001, 2'b01, 1, 0, 0, "itr_lock");

      // Illegal patterns in IDLE stay in IDLE.
      do_reset();
      step(1, 3'b000, 2'b00, 0, 1, 0, "idle_000");
      step(1, 3'b011, 2'b00, 0, 1, 0, "idle_011");
      step(1, 3'b110, 2'b00, 0, 1, 0, "idle_110");
      step(1, 3'b010, 2'b00, 0, 0, 0, "idle_store");
      step(1, 3'b100, 2'b00, 0, 0, 0, "idle_then_r1");

      // Holds and gated cycles never count; async reset while locked.
      do_reset();
      step(1, 3'b010, 2'b00, 0, 0, 0, "hold_first");
      step(0, 3'b000, 2'b00, 0, 0, 0, "hold_gap1");
      step(1, 3'b010, 2'b00, 0, 0, 0, "hold_same1");
      step(0, 3'b100, 2'b00, 0, 0, 0, "hold_gap2");
      step(1, 3'b010, 2'b00, 0, 0, 0, "hold_same2");
      step(1, 3'b100, 2'b00, 0, 0, 0, "hold_r1");
      step(1, 3'b100, 2'b00, 0, 0, 0, "hold_keep1");
      step(1, 3'b001, 2'b00, 0, 0, 0, "hold_r2");
      step(1, 3'b001, 2'b00, 0, 0, 0, "hold_keep2");
      step(1, 3'b010, 2'b01, 1, 0, 0, "hold_lock");
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      chk("async_reset", {wind, locked, err, dir_change}, 5'b0);
      @(negedge clk);
      reset_n = 1'b1;
      step(1, 3'b010, 2'b00, 0, 0, 0, "post_reset_first");
      step(1, 3'b100, 2'b00, 0, 0, 0, "post_reset_r1");

`ifdef RUNWAY_DEC_STATS_EN
      do_reset();
      for (int i = 0; i < 300; i++) step(1, 3'b000, 2'b00, 0, 1, 0, "stats_err");
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (err_count === 8'd255) n_pass++;
      else $display("FAIL stats_saturate: got %0d, expected 255", err_count);
`endif

      @(negedge clk);
      sample_valid = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/runway_pattern_decoder.md
RUNWAY_PATTERN_DECODER -- requirements
Module: runway_pattern_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 3, legal 1..15: number of consecutive same-class transitions required for lock.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 lights  input  3  observed runway light pattern, bit 2 = leftmost lamp.
REQ-005 sample_valid  input  1  lights sampled only on cycles where high.
REQ-006 wind  output  2  decoded direction: 00 calm, 01 leftward (001->010->100), 10 rightward (100->010->001); 11 never driven.
REQ-007 locked  output  1  high while wind is a confirmed decode.
REQ-008 err  output  1  one-cycle pulse on illegal pattern or illegal transition.
REQ-009 dir_change  output  1  one-cycle pulse when a locked wind value changes.

Function
REQ-010 Legal patterns SHALL be 001, 010, 100, 101; 000, 011, 110, 111 are illegal patterns.
REQ-011 Each valid sample with a stored previous pattern SHALL be classified: CALM (101<->010), LEFT (001->010, 010->100, 100->001), RIGHT (100->010, 010->001, 001->100), HOLD (same as previous), else ILLEGAL.
REQ-012 FSM states SHALL be IDLE (no previous pattern), TRACK (counting, unlocked), LOCKED.
REQ-013 IDLE: a legal valid sample SHALL store the pattern and go to TRACK with run=0; an illegal pattern SHALL pulse err and stay IDLE.
REQ-014 HOLD transitions SHALL change nothing: no count, no err.
REQ-015 A CALM/LEFT/RIGHT transition equal to the candidate class SHALL increment run (saturating at LOCK_COUNT); a different class SHALL set candidate=new class, run=1.
REQ-016 In TRACK, run reaching LOCK_COUNT SHALL load wind=candidate, assert locked, and move to LOCKED.
REQ-017 In LOCKED, wind SHALL hold its value until a different candidate reaches LOCK_COUNT; then wind updates, dir_change pulses on the same edge, locked stays high.
REQ-018 An illegal pattern in any state SHALL pulse err, clear locked, set wind=00, and go to IDLE.
REQ-019 An ILLEGAL transition between legal patterns SHALL pulse err, clear locked, set wind=00, store the new pattern, run=0, and go to TRACK.
REQ-020 All outputs SHALL be registered; response visible in the cycle after the sampling edge (latency 1).
REQ-021 With LOCK_COUNT=1, the first classified transition SHALL lock immediately.
REQ-022 Cycles with sample_valid low SHALL hold all state; err and dir_change are low.

Reset
REQ-023 reset_n low SHALL immediately force IDLE, wind=00, locked=0, err=0, dir_change=0, run=0, previous pattern invalid.
REQ-024 Reset asserted mid-run SHALL discard all progress; the first sample after release is treated as the first sample.

Configuration
REQ-025 Macro RUNWAY_DEC_STATS_EN defined: adds output err_count (8 bits), incremented on every err pulse, saturating at 255, cleared by reset.
REQ-026 Macro undefined: err_count port and its counter are absent; all other behaviour is identical.

Structure
REQ-027 Package runway_pkg SHALL hold the wind encoding enum, the step-class enum (CALM, LEFT, RIGHT, HOLD, ILLEGAL) and the four legal pattern constants.
REQ-028 Combinational sub-module runway_step_classify (prev pattern, current pattern -> step class, illegal-pattern flag) SHALL be instantiated once.

Verification
REQ-029 Reset, then valid samples 101,010,101,010 (LOCK_COUNT=3) -> locked=1, wind=00 one cycle after the 4th sample; err never pulses.
REQ-030 Samples 001,010,100,001 -> wind=01 locked; then 100,010,001,100 -> dir_change pulses once, wind=10, locked stays high throughout.
REQ-031 While locked on 01, sample 111 -> err pulse, locked=0, wind=00; following 001,010,100,001 relocks wind=01.
REQ-032 Samples 101,001 -> err pulse, state TRACK; 010,100,001 then locks wind=01.
REQ-033 Samples 010,010,010 with sample_valid toggling -> no count, no err; reset_n pulled low mid-run -> all outputs 0 asynchronously.
REQ-034 With RUNWAY_DEC_STATS_EN defined, 300 illegal samples -> err_count=255.
